// File: rtl/encoder_16x4_checker_if.sv
// Handshake bundle for the 16-to-4 encoder: input word stream in, encoded index plus flags out.
interface encoder_16x4_checker_if;
    logic [15:0] d_in;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  d_out;
    logic        out_valid;
    logic        out_ready;
    logic        err_zero;
    logic        err_multi;

    modport master (
        output d_in, in_valid, out_ready,
        input  in_ready, d_out, out_valid, err_zero, err_multi
    );

    modport slave (
        input  d_in, in_valid, out_ready,
        output in_ready, d_out, out_valid, err_zero, err_multi
    );
endinterface

// File: rtl/encoder_16x4_checker.sv
// One-hot to binary encoder with a single-entry output register, zero/multi-hot error flags,
// a saturating error counter and a sticky record of every code seen.
module encoder_16x4_checker #(
    parameter int CNT_W    = 8,
    parameter bit LOW_PRIO = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    encoder_16x4_checker_if.slave bus,
    input  logic                clr,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [15:0]         seen_mask,
    output logic                all_seen
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state;
    logic        out_valid;
    logic        accept;
    logic        consume;
    logic [3:0]  enc_idx;
    logic [4:0]  ones;
    logic        is_zero;
    logic        is_multi;
    logic        is_onehot;

    assign out_valid     = (state == FULL);
    assign bus.out_valid = out_valid;
    assign bus.in_ready  = !out_valid || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign consume       = out_valid && bus.out_ready;
    assign all_seen      = &seen_mask;

    // Scan direction chosen so the preferred index is the last one written.
    always_comb begin
        enc_idx = '0;
        ones    = '0;
        for (int unsigned j = 0; j < 16; j++) begin
            int unsigned i;
            i = LOW_PRIO ? (15 - j) : j;
            if (bus.d_in[i]) begin
                enc_idx = 4'(i);
                ones    = ones + 5'd1;
            end
        end
    end

    assign is_zero   = (ones == 5'd0);
    assign is_multi  = (ones > 5'd1);
    assign is_onehot = (ones == 5'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            bus.d_out     <= '0;
            bus.err_zero  <= 1'b0;
            bus.err_multi <= 1'b0;
            err_cnt       <= '0;
            seen_mask     <= '0;
        end else begin
            if (accept) begin
                state         <= FULL;
                bus.d_out     <= enc_idx;
                bus.err_zero  <= is_zero;
                bus.err_multi <= is_multi;
            end else if (consume) begin
                state <= EMPTY;
            end

            // Clear takes priority over bookkeeping of a word accepted in the same cycle.
            if (clr) begin
                err_cnt   <= '0;
                seen_mask <= '0;
            end else if (accept) begin
                if ((is_zero || is_multi) && (err_cnt != '1))
                    err_cnt <= err_cnt + CNT_W'(1);
                if (is_onehot)
                    seen_mask[enc_idx] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_encoder_16x4_checker.sv
// Drives two encoder instances (8-bit counter / low priority, 2-bit counter / high priority)
// with identical directed traffic and checks them against a word-level reference model.
module tb_encoder_16x4_checker;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] d_in;
    logic        in_valid;
    logic        out_ready;
    logic        clr;

    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;
    logic [15:0] seen_a, seen_b;
    logic        all_a, all_b;

    int errs   = 0;
    int checks = 0;

    encoder_16x4_checker_if ifa ();
    encoder_16x4_checker_if ifb ();

    assign ifa.d_in = d_in;  assign ifa.in_valid = in_valid;  assign ifa.out_ready = out_ready;
    assign ifb.d_in = d_in;  assign ifb.in_valid = in_valid;  assign ifb.out_ready = out_ready;

    encoder_16x4_checker #(.CNT_W(8), .LOW_PRIO(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .clr(clr),
        .err_cnt(cnt_a), .seen_mask(seen_a), .all_seen(all_a)
    );

    encoder_16x4_checker #(.CNT_W(2), .LOW_PRIO(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .clr(clr),
        .err_cnt(cnt_b), .seen_mask(seen_b), .all_seen(all_b)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 is dut_a, index 1 is dut_b.
    localparam bit LOWP [2] = '{1'b1, 1'b0};
    localparam int MAXC [2] = '{255, 3};
    bit          m_valid [2];
    int          m_dout  [2];
    bit          m_zero  [2];
    bit          m_multi [2];
    int          m_cnt   [2];
    logic [15:0] m_seen  [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_valid[d] = 0; m_dout[d] = 0; m_zero[d] = 0; m_multi[d] = 0;
                m_cnt[d] = 0; m_seen[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int n, lo, hi;
                bit acc;
                n = 0; lo = -1; hi = -1;
                for (int i = 0; i < 16; i++)
                    if (d_in[i]) begin
                        n++;
                        if (lo < 0) lo = i;
                        hi = i;
                    end
                acc = in_valid && (!m_valid[d] || out_ready);
                if (acc) begin
                    m_valid[d] = 1;
                    m_zero[d]  = (n == 0);
                    m_multi[d] = (n > 1);
                    m_dout[d]  = (n == 0) ? 0 : (LOWP[d] ? lo : hi);
                end else if (out_ready) begin
                    m_valid[d] = 0;
                end
                if (clr) begin
                    m_cnt[d] = 0; m_seen[d] = '0;
                end else if (acc) begin
                    if (n != 1 && m_cnt[d] < MAXC[d]) m_cnt[d]++;
                    if (n == 1) m_seen[d][lo] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("a.in_ready",  ifa.in_ready,  (!m_valid[0] || out_ready) ? 1 : 0);
            chk("b.in_ready",  ifb.in_ready,  (!m_valid[1] || out_ready) ? 1 : 0);
            chk("a.out_valid", ifa.out_valid, m_valid[0]);
            chk("b.out_valid", ifb.out_valid, m_valid[1]);
            chk("a.err_cnt",   cnt_a, m_cnt[0]);
            chk("b.err_cnt",   cnt_b, m_cnt[1]);
            chk("a.seen_mask", seen_a, m_seen[0]);
            chk("b.seen_mask", seen_b, m_seen[1]);
            chk("a.all_seen",  all_a, (m_seen[0] == 16'hFFFF) ? 1 : 0);
            chk("b.all_seen",  all_b, (m_seen[1] == 16'hFFFF) ? 1 : 0);
            if (m_valid[0]) begin
                chk("a.d_out", ifa.d_out, m_dout[0]);
                chk("a.err_zero", ifa.err_zero, m_zero[0]);
                chk("a.err_multi", ifa.err_multi, m_multi[0]);
            end
            if (m_valid[1]) begin
                chk("b.d_out", ifb.d_out, m_dout[1]);
                chk("b.err_zero", ifb.err_zero, m_zero[1]);
                chk("b.err_multi", ifb.err_multi, m_multi[1]);
            end
        end
    end

    task automatic step(input logic [15:0] d, input logic v, input logic r, input logic c);
        d_in = d; in_valid = v; out_ready = r; clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int sat_exp [5] = '{1, 2, 3, 3, 3};
        rst_n = 1'b0; d_in = '0; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
        #1;
        chk("rst.in_ready",  ifa.in_ready, 1);
        chk("rst.out_valid", ifa.out_valid, 0);
        chk("rst.d_out",     ifa.d_out, 0);
        chk("rst.err_cnt",   cnt_a, 0);
        chk("rst.seen",      seen_a, 0);
        #11;
        rst_n = 1'b1;
        #1;
        chk("post_rst.in_ready", ifa.in_ready, 1);
        @(posedge clk); #1;

        // One-hot sweep, one word per cycle
        for (int k = 0; k < 16; k++) begin
            step(16'(1 << k), 1'b1, 1'b1, 1'b0);
            chk("sweep.d_out", ifa.d_out, k);
            chk("sweep.flags", {ifa.err_zero, ifa.err_multi}, 0);
        end
        chk("sweep.all_seen_a", all_a, 1);
        chk("sweep.all_seen_b", all_b, 1);
        chk("sweep.err_cnt",    cnt_a, 0);

        step(16'h0000, 1'b0, 1'b1, 1'b1);
        chk("clr.seen", seen_a, 0);

        // Backpressure
        step(16'h0010, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(16'h0100, 1'b1, 1'b0, 1'b0);
            chk("bp.d_out_hold", ifa.d_out, 4);
            chk("bp.in_ready",   ifa.in_ready, 0);
        end
        step(16'h0100, 1'b1, 1'b1, 1'b0);
        chk("bp.d_out_next", ifa.d_out, 8);

        // Error words
        step(16'h0000, 1'b1, 1'b1, 1'b0);
        chk("err0.d_out", ifa.d_out, 0);
        chk("err0.err_zero", ifa.err_zero, 1);
        step(16'h8001, 1'b1, 1'b1, 1'b0);
        chk("errm.d_out_a", ifa.d_out, 0);
        chk("errm.d_out_b", ifb.d_out, 15);
        chk("errm.err_multi", ifa.err_multi, 1);
        chk("errm.err_cnt", cnt_a, 2);
        chk("errm.seen", seen_a, 16'h0110);
        step(16'h0A00, 1'b1, 1'b1, 1'b0);
        chk("a0a00.d_out_a", ifa.d_out, 9);
        chk("a0a00.d_out_b", ifb.d_out, 11);

        // Saturation of the 2-bit counter
        step(16'h0000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(16'h0000, 1'b1, 1'b1, 1'b0);
            chk("sat.cnt_b", cnt_b, sat_exp[i]);
        end
        chk("sat.cnt_a", cnt_a, 5);
        step(16'h0000, 1'b1, 1'b1, 1'b1);
        chk("sat.clr_b", cnt_b, 0);
        chk("sat.clr_a", cnt_a, 0);
        chk("sat.clr_word_zero", ifa.err_zero, 1);

        // Decoder with bit 2 of the code stuck low
        for (int c = 0; c < 16; c++)
            step(16'(1 << (c & 4'b1011)), 1'b1, 1'b1, 1'b0);
        chk("stuck.seen", seen_a, 16'h0F0F);
        chk("stuck.all_seen", all_a, 0);
        step(16'h0000, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset while holding a word
        step(16'h0080, 1'b1, 1'b0, 1'b0);
        chk("ar.d_out", ifa.d_out, 7);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar.out_valid", ifa.out_valid, 0);
        chk("ar.err_cnt",   cnt_a, 0);
        chk("ar.seen",      seen_a, 0);
        chk("ar.in_ready",  ifa.in_ready, 1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        chk("ar.in_ready_after", ifa.in_ready, 1);
        @(posedge clk); #1;
        step(16'h0008, 1'b1, 1'b1, 1'b0);
        chk("ar.resume_d_out", ifa.d_out, 3);
        chk("ar.resume_seen",  seen_a, 16'h0008);
        step(16'h0000, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/encoder_16x4_checker.md
ENCODER_16X4_CHECKER -- requirements
Module: encoder_16x4_checker

Interface
REQ-001 Parameter CNT_W, default 8: width of the error counter err_cnt.
REQ-002 Parameter LOW_PRIO, default 1: 1 means multi-hot inputs encode the lowest set index; 0 means they encode the highest set index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 d_in  input  16  one-hot code word to encode; bit k set means code k.
REQ-006 in_valid  input  1  d_in is valid this cycle.
REQ-007 in_ready  output  1  block accepts d_in this cycle.
REQ-008 d_out  output  4  encoded index of the accepted word.
REQ-009 out_valid  output  1  d_out and its flags are valid.
REQ-010 out_ready  input  1  downstream consumes d_out this cycle.
REQ-011 err_zero  output  1  the word held in d_out had no bit set; qualified by out_valid.
REQ-012 err_multi  output  1  the word held in d_out had more than one bit set; qualified by out_valid.
REQ-013 err_cnt  output  CNT_W  saturating count of accepted words with err_zero or err_multi.
REQ-014 clr  input  1  synchronous clear of err_cnt and seen_mask.
REQ-015 seen_mask  output  16  bit k is sticky-set once a valid one-hot word for code k has been accepted.
REQ-016 all_seen  output  1  seen_mask equals 16'hFFFF.

Function
REQ-017 Accept occurs when in_valid and in_ready are both 1; consume occurs when out_valid and out_ready are both 1.
REQ-018 The output is a single register stage with an implicit two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 in_ready is combinational and equals (!out_valid || out_ready), so back-to-back throughput is one word per cycle.
REQ-020 In EMPTY, an accept moves the FSM to FULL.
REQ-021 In FULL, a consume with no accept moves the FSM to EMPTY.
REQ-022 In FULL, a consume with a simultaneous accept keeps the FSM in FULL and loads the new word.
REQ-023 In FULL, if out_ready=0 then d_out, err_zero and err_multi hold stable and in_ready=0.
REQ-024 Latency: an accepted word appears on d_out with out_valid=1 on the next rising edge.
REQ-025 One-hot input: d_out is the index of the set bit; err_zero=0 and err_multi=0.
REQ-026 All-zero input: d_out=4'h0, err_zero=1, err_multi=0.
REQ-027 Two or more bits set: err_multi=1, err_zero=0, and d_out follows LOW_PRIO.
REQ-028 Example: d_in=16'h0A00 gives d_out=9 when LOW_PRIO=1 and d_out=11 when LOW_PRIO=0.
REQ-029 err_cnt increments by 1 on each accept whose word is zero-hot or multi-hot.
REQ-030 err_cnt saturates at 2^CNT_W-1 and never wraps.
REQ-031 clr=1 sets err_cnt to 0 and seen_mask to 0 on the next edge.
REQ-032 When clr coincides with an erroneous or one-hot accept, clr wins and that word is not counted or recorded; the word itself is still encoded and output.
REQ-033 seen_mask bit k is set only on accepts of exact one-hot words; zero-hot and multi-hot words never change seen_mask.
REQ-034 all_seen is a combinational function of seen_mask.
REQ-035 d_in is ignored, and no counter or mask update occurs, when there is no accept.

Reset
REQ-036 While rst_n=0: out_valid=0, d_out=0, err_zero=0, err_multi=0, err_cnt=0, seen_mask=0, FSM=EMPTY.
REQ-037 Reset takes effect immediately on the falling edge of rst_n, independent of clk.
REQ-038 Assertion mid-transfer discards any held word without a consume.
REQ-039 in_ready=1 while in reset and in the first cycle after rst_n deasserts.

Verification
REQ-040 Sweep k=0..15 with d_in=1<<k, out_ready=1, in_valid held 1 -> d_out=k one cycle after each accept, one word per cycle, no error flags, all_seen=1 after 16 accepts, err_cnt=0.
REQ-041 Backpressure: accept 16'h0010 with out_ready=0 for 3 cycles -> d_out=4 holds and in_ready=0 throughout; on out_ready=1, a pending 16'h0100 is accepted the same cycle and d_out=8 follows.
REQ-042 Error words 16'h0000 then 16'h8001 (LOW_PRIO=1) -> first output d_out=0 with err_zero=1, second output d_out=0 with err_multi=1; err_cnt=2 and seen_mask unchanged.
REQ-043 Saturation with CNT_W=2: 5 zero-hot accepts -> err_cnt reads 1, 2, 3, 3, 3; clr together with a 6th error -> err_cnt=0.
REQ-044 Drop rst_n between clock edges while FULL with d_out=7 -> out_valid, err_cnt and seen_mask read 0 before the next edge.
REQ-045 Mimic a decoder with bit 2 stuck at 0 by masking d_in codes with 4'b1011 and sweeping all 16 codes -> seen_mask=16'h0F0F and all_seen=0.
